// File: rtl/cu_pair_feeder_if.sv
// Coefficient-RAM read port plus the pair push port toward compute_unit.
// The master side is the feeder; the slave side is the RAM / compute_unit.
interface cu_pair_feeder_if #(
    parameter int DW = 12,
    parameter int AW = 8
);
    logic          mem_rd;
    logic [AW-1:0] mem_raddr1;
    logic [AW-1:0] mem_raddr2;
    logic [DW-1:0] mem_rdat1;
    logic [DW-1:0] mem_rdat2;
    logic [DW-1:0] odat1;
    logic [DW-1:0] odat2;
    logic          odatwr;
    logic          inrdy;

    modport master (
        output mem_rd, mem_raddr1, mem_raddr2, odat1, odat2, odatwr,
        input  mem_rdat1, mem_rdat2, inrdy
    );

    modport slave (
        input  mem_rd, mem_raddr1, mem_raddr2, odat1, odat2, odatwr,
        output mem_rdat1, mem_rdat2, inrdy
    );
endinterface

// File: rtl/cu_pair_feeder.sv
// Sweeps one butterfly layer, reading (a[j], a[j+len]) pairs from a dual-read RAM
// and pushing them to compute_unit through a 2-entry skid buffer.
module cu_pair_feeder #(
    parameter int DW = 12,
    parameter int N  = 256,
    parameter int AW = 8,
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] lenlog,
    output logic          busy,
    output logic          done,
    cu_pair_feeder_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int unsigned  NP   = N / 2;
    localparam logic [LW:0]  LMAX = (LW+1)'(AW - 1);

    logic [1:0]      state;
    logic [LW-1:0]   ll;
    logic [AW-2:0]   p;
    logic            inflight;
    logic [AW-1:0]   a1_q, a2_q;

    logic [1:0]      occ;
    logic [2*DW-1:0] head, tail, din;

    logic [AW-1:0]   p_ext, len, a1, a2;
    logic [2:0]      credit;
    logic            issue, pop, push, last_p, done_c;

    always_comb begin
        p_ext  = {1'b0, p};
        len    = AW'(1) << ll;
        // zero bit inserted at position ll: low bits stay, high bits shift up by one
        a1     = ((p_ext >> ll) << ({1'b0, ll} + (LW+1)'(1))) | (p_ext & (len - AW'(1)));
        a2     = a1 + len;
        pop    = (occ != 2'd0) & bus.inrdy;
        push   = inflight;
        credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        issue  = (state == S_RUN) & (credit < 3'd2);
        last_p = (p == (AW-1)'(NP - 1));
        done_c = (state == S_DRAIN) & ~inflight & (occ == 2'd0);
        din    = {bus.mem_rdat1, bus.mem_rdat2};
    end

    assign bus.mem_rd     = issue;
    assign bus.mem_raddr1 = issue ? a1 : a1_q;
    assign bus.mem_raddr2 = issue ? a2 : a2_q;
    assign bus.odat1      = head[2*DW-1:DW];
    assign bus.odat2      = head[DW-1:0];
    assign bus.odatwr     = pop;
    assign done           = done_c;
    assign busy           = (state != S_IDLE) & ~done_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            ll       <= '0;
            p        <= '0;
            inflight <= 1'b0;
            a1_q     <= '0;
            a2_q     <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                a1_q <= a1;
                a2_q <= a2;
                p    <= p + (AW-1)'(1);
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ll    <= ({1'b0, lenlog} > LMAX) ? LMAX[LW-1:0] : lenlog;
                        p     <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue && last_p)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (done_c)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // head is always the oldest entry; a simultaneous push/pop shifts tail into head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ  <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0)
                        head <= din;
                    else
                        tail <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cu_pair_feeder.sv
// Randomized scoreboard bench for cu_pair_feeder: expected pairs come from the
// textbook butterfly loop nest over a RAM image with unique per-address contents.
module tb_cu_pair_feeder;
    localparam int DW = 12;
    localparam int N  = 256;
    localparam int AW = 8;
    localparam int LW = 3;
    localparam int NP = N / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] lenlog = '0;
    logic          busy, done;

    cu_pair_feeder_if #(.DW(DW), .AW(AW)) bus ();

    cu_pair_feeder #(.DW(DW), .N(N), .AW(AW), .LW(LW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .lenlog (lenlog),
        .busy   (busy),
        .done   (done),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0]   mem [N];
    logic [2*DW-1:0] exp_q [$];
    int cyc = 0;
    int checks = 0, failures = 0;
    int done_cnt = 0, done_cyc = 0, first_wr_cyc = 0;
    int sweep_pairs = 0, sweep_rd = 0, rd_cnt = 0, wr_cnt = 0;
    int start_cyc = 0, inrdy_mode = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, got, req, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // RAM: data valid exactly one cycle after mem_rd, junk otherwise
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_rdat1 <= mem[bus.mem_raddr1];
            bus.mem_rdat2 <= mem[bus.mem_raddr2];
        end else begin
            bus.mem_rdat1 <= DW'($urandom);
            bus.mem_rdat2 <= DW'($urandom);
        end
    end

    initial begin
        bus.inrdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (inrdy_mode)
                1: begin
                    if ((cyc - start_cyc) >= 10 && (cyc - start_cyc) <= 14)
                        bus.inrdy = 1'b0;
                    else if ((cyc - start_cyc) > 14)
                        bus.inrdy = ((cyc - start_cyc) % 2) == 0;
                    else
                        bus.inrdy = 1'b1;
                end
                2:       bus.inrdy = $urandom_range(0, 3) != 0;
                default: bus.inrdy = 1'b1;
            endcase
        end
    end

    // monitor: pops the scoreboard on every transfer
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (bus.odatwr) begin
                wr_cnt++;
                if (sweep_pairs == 0) first_wr_cyc = cyc;
                sweep_pairs++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pair actual=%0h required=none (cycle %0d)",
                             {bus.odat1, bus.odat2}, cyc);
                end else begin
                    chk("pair", 64'({bus.odat1, bus.odat2}), 64'(exp_q.pop_front()));
                end
            end
            if (bus.mem_rd) begin
                rd_cnt++;
                sweep_rd++;
                chk("read_credit_overrun", 64'(rd_cnt - wr_cnt > 2), 64'(0));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_low_in_done", 64'(busy), 64'(0));
            end
        end
    end

    task automatic push_exp(input int ll);
        int len;
        len = 1 << ll;
        for (int b = 0; b < N; b += 2 * len)
            for (int j = b; j < b + len; j++)
                exp_q.push_back({mem[j], mem[j + len]});
    endtask

    // called right after a posedge; returns right after the posedge ending the done cycle
    task automatic run_cmd(input int ll, input int mode, input bit lat, input int poke);
        int c0, d0, n;
        push_exp(ll);
        sweep_pairs = 0;
        sweep_rd    = 0;
        d0          = done_cnt;
        #1;
        inrdy_mode = mode;
        start_cyc  = cyc;
        c0         = cyc;
        start      = 1'b1;
        lenlog     = LW'(ll);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(posedge clk);
            n++;
            if (poke > 0 && n == poke) begin
                #1;
                start  = 1'b1;
                lenlog = LW'((ll + 3) % 8);
            end else if (poke > 0 && n == poke + 1) begin
                #1;
                start  = 1'b0;
                lenlog = LW'(ll);
            end
        end
        chk("done_seen", 64'(done_cnt - d0), 64'(1));
        chk("pairs_per_cmd", 64'(sweep_pairs), 64'(NP));
        chk("reads_per_cmd", 64'(sweep_rd), 64'(NP));
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        if (lat) begin
            chk("first_odatwr_cycle", 64'(first_wr_cyc - c0), 64'(3));
            chk("done_cycle", 64'(done_cyc - c0), 64'(NP + 3));
        end
        exp_q.delete();
    endtask

    initial begin
        int d;
        for (int i = 0; i < N; i++)
            mem[i] = DW'((i << 4) | $urandom_range(0, 15));

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({busy, done, bus.mem_rd, bus.mem_raddr1, bus.mem_raddr2,
                                   bus.odat1, bus.odat2, bus.odatwr}), 64'(0));
        rst = 1'b1;
        @(posedge clk);

        run_cmd(7, 0, 1'b1, 0);
        repeat (3) @(posedge clk);
        run_cmd(0, 0, 1'b1, 0);
        repeat (3) @(posedge clk);
        run_cmd(3, 1, 1'b0, 0);
        repeat (3) @(posedge clk);

        d = done_cnt;
        run_cmd(5, 0, 1'b1, 49);
        repeat (5) @(posedge clk);
        chk("single_done_despite_restart", 64'(done_cnt - d), 64'(1));

        // abort mid-sweep with reset
        push_exp(4);
        #1;
        inrdy_mode = 0;
        start      = 1'b1;
        lenlog     = LW'(4);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (38) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_midsweep_outputs", 64'({busy, done, bus.mem_rd, bus.mem_raddr1, bus.mem_raddr2,
                                            bus.odat1, bus.odat2, bus.odatwr}), 64'(0));
        exp_q.delete();
        d = done_cnt;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        chk("no_done_after_abort", 64'(done_cnt - d), 64'(0));
        run_cmd(4, 0, 1'b1, 0);
        repeat (3) @(posedge clk);

        run_cmd(7, 0, 1'b1, 0);
        run_cmd(7, 0, 1'b1, 0);
        repeat (3) @(posedge clk);

        repeat (4) begin
            run_cmd(int'($urandom_range(0, 7)), 2, 1'b0, 0);
            repeat (2) @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
